car_sprite_engine: RTL and testbench

Pixel-generation datapath for the car sprite. It sits directly downstream of the animation control FSM, which drives it with `drawCarEnable`, `eraseCarEnable` and `ldXY` and waits on its `drawCarDone` and `eraseCarDone` outputs. On a draw request it scans the car sprite ROM and plots opaque pixels at the latched car position. On an erase request it restores the same footprint from the background (map) ROM. Its pixel outputs feed the VGA adapter's plot port.

---
 rtl/car_sprite_if.sv | 29 ++
 rtl/car_sprite_engine.sv | 130 +++++++++++++
 tb/tb_car_sprite_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/car_sprite_if.sv
// Request/plot bundle between the car animation control, the sprite/background ROMs,
// the VGA adapter and the car sprite engine.
interface car_sprite_if;
    logic       ldXY;
    logic [7:0] car_x;
    logic [6:0] car_y;
    logic       drawCarEnable;
    logic       eraseCarEnable;
    logic [2:0] sprite_colour;
    logic [2:0] bg_colour;
    logic [5:0] sprite_addr;
    logic [14:0] bg_addr;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       drawCarDone;
    logic       eraseCarDone;

    modport master (
        output ldXY, car_x, car_y, drawCarEnable, eraseCarEnable, sprite_colour, bg_colour,
        input  sprite_addr, bg_addr, vga_x, vga_y, vga_colour, vga_plot, drawCarDone, eraseCarDone
    );

    modport slave (
        input  ldXY, car_x, car_y, drawCarEnable, eraseCarEnable, sprite_colour, bg_colour,
        output sprite_addr, bg_addr, vga_x, vga_y, vga_colour, vga_plot, drawCarDone, eraseCarDone
    );
endinterface

// File: rtl/car_sprite_engine.sv
// Scans the car footprint one pixel per clock: draws opaque sprite pixels, or restores
// the same footprint from the background ROM, at the last latched car position.
module car_sprite_engine #(
    parameter int unsigned CAR_W       = 8,
    parameter int unsigned CAR_H       = 8,
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter logic [2:0]  TRANSPARENT = 3'b000
) (
    input  logic         clk,
    input  logic         resetn,
    car_sprite_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned CXW = (CAR_W > 1) ? $clog2(CAR_W) : 1;
    localparam int unsigned CYW = (CAR_H > 1) ? $clog2(CAR_H) : 1;
    localparam int unsigned AXW = 9;
    localparam int unsigned AYW = 8;

    logic [1:0]     state, state_nx;
    logic [CXW-1:0] cx, cx_nx;
    logic [CYW-1:0] cy, cy_nx;
    logic [7:0]     pos_x, pos_x_nx;
    logic [6:0]     pos_y, pos_y_nx;
    logic           draw_mode, draw_mode_nx;
    logic [AXW-1:0] stage_x, stage_x_nx;
    logic [AYW-1:0] stage_y, stage_y_nx;
    logic           stage_valid, stage_valid_nx;

    logic           mode_en_c;
    logic [AXW-1:0] abs_x_c;
    logic [AYW-1:0] abs_y_c;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cx          <= '0;
            cy          <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            draw_mode   <= 1'b0;
            stage_x     <= '0;
            stage_y     <= '0;
            stage_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            cx          <= cx_nx;
            cy          <= cy_nx;
            pos_x       <= pos_x_nx;
            pos_y       <= pos_y_nx;
            draw_mode   <= draw_mode_nx;
            stage_x     <= stage_x_nx;
            stage_y     <= stage_y_nx;
            stage_valid <= stage_valid_nx;
        end
    end

    assign mode_en_c = draw_mode ? bus.drawCarEnable : bus.eraseCarEnable;
    assign abs_x_c   = AXW'(pos_x) + AXW'(cx);
    assign abs_y_c   = AYW'(pos_y) + AYW'(cy);

    // Next state; dropping the latched mode's enable mid-scan aborts straight to IDLE.
    always_comb begin
        state_nx       = state;
        cx_nx          = cx;
        cy_nx          = cy;
        pos_x_nx       = pos_x;
        pos_y_nx       = pos_y;
        draw_mode_nx   = draw_mode;
        stage_x_nx     = stage_x;
        stage_y_nx     = stage_y;
        stage_valid_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.ldXY) begin
                    pos_x_nx = bus.car_x;
                    pos_y_nx = bus.car_y;
                end
                if (bus.drawCarEnable || bus.eraseCarEnable) begin
                    state_nx     = S_SCAN;
                    draw_mode_nx = bus.drawCarEnable;
                    cx_nx        = '0;
                    cy_nx        = '0;
                end
            end
            S_SCAN: begin
                if (!mode_en_c) begin
                    state_nx = S_IDLE;
                end else begin
                    stage_x_nx     = abs_x_c;
                    stage_y_nx     = abs_y_c;
                    stage_valid_nx = 1'b1;
                    if (cx == CXW'(CAR_W - 1)) begin
                        cx_nx = '0;
                        if (cy == CYW'(CAR_H - 1)) begin
                            cy_nx    = '0;
                            state_nx = S_DRAIN;
                        end else begin
                            cy_nx = cy + CYW'(1);
                        end
                    end else begin
                        cx_nx = cx + CXW'(1);
                    end
                end
            end
            S_DRAIN: state_nx = mode_en_c ? S_DONE : S_IDLE;
            default: if (!mode_en_c) state_nx = S_IDLE;
        endcase
    end

    assign bus.sprite_addr = 6'(32'(cy) * CAR_W + 32'(cx));
    assign bus.bg_addr     = 15'(32'(abs_y_c) * SCREEN_W + 32'(abs_x_c));

    // ROM data arrives one cycle after its address, aligned with the stage register.
    assign bus.vga_x      = stage_x[7:0];
    assign bus.vga_y      = stage_y[6:0];
    assign bus.vga_colour = !stage_valid ? 3'b000 :
                            (draw_mode ? bus.sprite_colour : bus.bg_colour);
    assign bus.vga_plot   = stage_valid
                            && (32'(stage_x) < SCREEN_W)
                            && (32'(stage_y) < SCREEN_H)
                            && (!draw_mode || (bus.sprite_colour != TRANSPARENT));

    assign bus.drawCarDone  = (state == S_DONE) && draw_mode;
    assign bus.eraseCarDone = (state == S_DONE) && !draw_mode;
endmodule

// File: tb/tb_car_sprite_engine.sv
// Directed bench for car_sprite_engine with registered sprite/background ROM models.
module tb_car_sprite_engine;
    logic clk;
    logic resetn;
    car_sprite_if bus ();

    car_sprite_engine dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [2:0] spr [64];

    function automatic logic [2:0] bgf(input logic [14:0] a);
        return a[2:0] ^ a[5:3] ^ 3'd5;
    endfunction

    always @(posedge clk) begin
        bus.sprite_colour <= spr[bus.sprite_addr];
        bus.bg_colour     <= bgf(bus.bg_addr);
    end

    int vectors = 0;
    int miscompares = 0;

    int pc[$];
    int px[$];
    int py[$];
    int pcol[$];
    logic dd [128];
    logic ed [128];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] x, input logic [6:0] y);
        bus.ldXY  = 1'b1;
        bus.car_x = x;
        bus.car_y = y;
        @(negedge clk);
        bus.ldXY = 1'b0;
        @(negedge clk);
    endtask

    // Caller raises an enable at a negedge (cycle 0); cycle c is sampled at the c-th negedge after.
    task automatic run(input int ncyc, input int drop_at, input int ld_at,
                       input logic [7:0] lx, input logic [6:0] ly);
        pc.delete(); px.delete(); py.delete(); pcol.delete();
        for (int c = 0; c < 128; c++) begin
            dd[c] = 1'b0;
            ed[c] = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (bus.vga_plot === 1'b1) begin
                pc.push_back(c);
                px.push_back(32'(bus.vga_x));
                py.push_back(32'(bus.vga_y));
                pcol.push_back(32'(bus.vga_colour));
            end
            dd[c] = bus.drawCarDone;
            ed[c] = bus.eraseCarDone;
            if (c == ld_at) begin
                bus.ldXY  = 1'b1;
                bus.car_x = lx;
                bus.car_y = ly;
            end else begin
                bus.ldXY = 1'b0;
            end
            if (c == drop_at) begin
                bus.drawCarEnable  = 1'b0;
                bus.eraseCarEnable = 1'b0;
            end
        end
    endtask

    function automatic int count_ones(input int from, input int to, input logic erase_flag);
        int n = 0;
        for (int c = from; c <= to; c++) n += int'(erase_flag ? ed[c] : dd[c]);
        return n;
    endfunction

    initial begin
        int k;
        int late;
        for (int i = 0; i < 64; i++) spr[i] = 3'((i % 7) + 1);
        resetn             = 1'b0;
        bus.ldXY           = 1'b0;
        bus.car_x          = 8'd0;
        bus.car_y          = 7'd0;
        bus.drawCarEnable  = 1'b0;
        bus.eraseCarEnable = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst sprite_addr", 32'(bus.sprite_addr), 0);
        chk("rst bg_addr",     32'(bus.bg_addr), 0);
        chk("rst vga_x",       32'(bus.vga_x), 0);
        chk("rst vga_y",       32'(bus.vga_y), 0);
        chk("rst vga_colour",  32'(bus.vga_colour), 0);
        chk("rst vga_plot",    32'(bus.vga_plot), 0);
        chk("rst draw_done",   32'(bus.drawCarDone), 0);
        chk("rst erase_done",  32'(bus.eraseCarDone), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Opaque draw at (10,20); ldXY to (11,20) while holding done must be ignored.
        load(8'd10, 7'd20);
        bus.drawCarEnable = 1'b1;
        run(72, 70, 68, 8'd11, 7'd20);
        chk("draw count", 32'(pc.size()), 64);
        for (int i = 0; i < 64 && i < pc.size(); i++) begin
            chk($sformatf("draw cyc[%0d]", i), 32'(pc[i]), 32'(2 + i));
            chk($sformatf("draw x[%0d]", i), 32'(px[i]), 32'(10 + i % 8));
            chk($sformatf("draw y[%0d]", i), 32'(py[i]), 32'(20 + i / 8));
            chk($sformatf("draw col[%0d]", i), 32'(pcol[i]), 32'(spr[i]));
        end
        chk("draw done c65", 32'(dd[65]), 0);
        chk("draw done c66", 32'(dd[66]), 1);
        chk("draw done c70", 32'(dd[70]), 1);
        chk("draw done c71", 32'(dd[71]), 0);
        chk("draw no erase_done", 32'(count_ones(1, 72, 1'b1)), 0);

        // Erase restores the footprint drawn at x=10, not the later car_x=11.
        bus.eraseCarEnable = 1'b1;
        run(72, 70, 0, 8'd0, 7'd0);
        chk("erase count", 32'(pc.size()), 64);
        for (int i = 0; i < 64 && i < pc.size(); i++) begin
            chk($sformatf("erase x[%0d]", i), 32'(px[i]), 32'(10 + i % 8));
            chk($sformatf("erase y[%0d]", i), 32'(py[i]), 32'(20 + i / 8));
            chk($sformatf("erase col[%0d]", i), 32'(pcol[i]),
                32'(bgf(15'((20 + i / 8) * 160 + 10 + i % 8))));
        end
        chk("erase done c65", 32'(ed[65]), 0);
        chk("erase done c66", 32'(ed[66]), 1);
        chk("erase done c71", 32'(ed[71]), 0);
        chk("erase no draw_done", 32'(count_ones(1, 72, 1'b0)), 0);

        // Twelve transparent pixels are skipped but still take their cycle.
        for (int i = 0; i < 60; i += 5) spr[i] = 3'b000;
        load(8'd30, 7'd40);
        bus.drawCarEnable = 1'b1;
        run(72, 70, 0, 8'd0, 7'd0);
        chk("transp count", 32'(pc.size()), 52);
        k = 0;
        for (int i = 0; i < 64; i++) begin
            if (spr[i] != 3'b000 && k < pc.size()) begin
                chk($sformatf("transp cyc[%0d]", k), 32'(pc[k]), 32'(2 + i));
                chk($sformatf("transp x[%0d]", k), 32'(px[k]), 32'(30 + i % 8));
                chk($sformatf("transp y[%0d]", k), 32'(py[k]), 32'(40 + i / 8));
                k++;
            end
        end
        chk("transp done c65", 32'(dd[65]), 0);
        chk("transp done c66", 32'(dd[66]), 1);
        for (int i = 0; i < 64; i++) spr[i] = 3'((i % 7) + 1);

        // Bottom-right corner: only the on-screen 4x4 quadrant is plotted.
        load(8'd156, 7'd116);
        bus.drawCarEnable = 1'b1;
        run(72, 70, 0, 8'd0, 7'd0);
        chk("clip count", 32'(pc.size()), 16);
        for (int i = 0; i < 16 && i < pc.size(); i++) begin
            chk($sformatf("clip cyc[%0d]", i), 32'(pc[i]), 32'(2 + (i / 4) * 8 + i % 4));
            chk($sformatf("clip x[%0d]", i), 32'(px[i]), 32'(156 + i % 4));
            chk($sformatf("clip y[%0d]", i), 32'(py[i]), 32'(116 + i / 4));
        end
        chk("clip done c65", 32'(dd[65]), 0);
        chk("clip done c66", 32'(dd[66]), 1);

        // Abort: enable dropped in cycle 30.
        load(8'd10, 7'd20);
        bus.drawCarEnable = 1'b1;
        run(80, 30, 0, 8'd0, 7'd0);
        late = 0;
        foreach (pc[i]) if (pc[i] >= 31) late++;
        chk("abort count", 32'(pc.size()), 29);
        chk("abort late plots", 32'(late), 0);
        chk("abort no draw_done", 32'(count_ones(1, 80, 1'b0)), 0);
        chk("abort no erase_done", 32'(count_ones(1, 80, 1'b1)), 0);
        chk("abort state idle", 32'(dut.state), 0);

        // Both enables: draw mode wins; then reset mid-scan.
        bus.drawCarEnable  = 1'b1;
        bus.eraseCarEnable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("both plot c2", 32'(bus.vga_plot), 1);
                chk("both colour c2", 32'(bus.vga_colour), 32'(spr[0]));
                chk("both x c2", 32'(bus.vga_x), 10);
            end
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst sprite_addr", 32'(bus.sprite_addr), 0);
        chk("mrst bg_addr",     32'(bus.bg_addr), 0);
        chk("mrst vga_x",       32'(bus.vga_x), 0);
        chk("mrst vga_y",       32'(bus.vga_y), 0);
        chk("mrst vga_colour",  32'(bus.vga_colour), 0);
        chk("mrst vga_plot",    32'(bus.vga_plot), 0);
        chk("mrst draw_done",   32'(bus.drawCarDone), 0);
        chk("mrst erase_done",  32'(bus.eraseCarDone), 0);
        bus.drawCarEnable  = 1'b0;
        bus.eraseCarEnable = 1'b0;
        resetn = 1'b1;
        late = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.vga_plot !== 1'b0) late++;
        end
        chk("post-reset plots", 32'(late), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
